alu: RTL and testbench

ALU -- requirements
Module: alu

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_core.sv | 36 +++
 rtl/alu.sv | 82 ++++++++
 tb/tb_alu.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - select codes, mode encoding and output reset values for the 4-bit ALU
package alu_pkg;

    localparam int W = 4;

    localparam logic [W-1:0] S_ADD  = 4'b1001;
    localparam logic [W-1:0] S_SUB  = 4'b0110;
    localparam logic [W-1:0] S_XOR  = 4'b0110;
    localparam logic [W-1:0] S_AND  = 4'b1011;
    localparam logic [W-1:0] S_OR   = 4'b1110;
    localparam logic [W-1:0] S_NOTA = 4'b0000;
    localparam logic [W-1:0] S_ONES = 4'b0011;
    localparam logic [W-1:0] S_DBL  = 4'b1100;

    typedef enum logic {
        MODE_ARITH = 1'b0,
        MODE_LOGIC = 1'b1
    } mode_e;

    typedef struct packed {
        logic [W-1:0] y;
        logic         co_n;
        logic         p;
        logic         q;
        logic         aeqb;
    } alu_out_t;

    localparam alu_out_t OUT_RST = '{y: 4'b0000, co_n: 1'b1, p: 1'b1, q: 1'b1, aeqb: 1'b0};
    localparam logic     Z_RST   = 1'b0;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational 74181-compatible function (active-high data)
module alu_core
    import alu_pkg::*;
(
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] s,
    input  logic         M,
    input  logic         Ci_inverse,
    output logic [W-1:0] F,
    output logic         cout,
    output logic         P,
    output logic         Q
);

    logic [W-1:0] x;
    logic [W-1:0] g;
    logic [W:0]   sum;

    always_comb begin
        x   = a | (b & {W{s[0]}}) | (~b & {W{s[1]}});
        g   = (a & ~b & {W{s[2]}}) | (a & b & {W{s[3]}});
        sum = {1'b0, x} + {1'b0, g} + {{W{1'b0}}, ~Ci_inverse};
        if (mode_e'(M) == MODE_LOGIC) begin
            F    = ~(x ^ g);
            cout = 1'b0;
        end else begin
            F    = sum[W-1:0];
            cout = sum[W];
        end
        // Group lookahead terms are mode-independent
        P = ~(&x);
        Q = ~(g[3] | (x[3] & g[2]) | (&x[3:2] & g[1]) | (&x[3:1] & g[0]));
    end

endmodule

// File: rtl/alu.sv
// rtl/alu.sv - registered 4-bit ALU; optional zero flag Z under ALU_ZERO_FLAG_EN
module alu
    import alu_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] s,
    input  logic         M,
    input  logic         Ci_inverse,
    output logic [W-1:0] Y,
    output logic         Co_inverse,
    output logic         P,
    output logic         Q,
    output logic         AequalsB
`ifdef ALU_ZERO_FLAG_EN
    ,
    output logic         Z
`endif
);

    logic [W-1:0] core_f;
    logic         core_cout;
    logic         core_p;
    logic         core_q;
    alu_out_t     out_d;
    alu_out_t     out_q;

    alu_core u_core (
        .a          (a),
        .b          (b),
        .s          (s),
        .M          (M),
        .Ci_inverse (Ci_inverse),
        .F          (core_f),
        .cout       (core_cout),
        .P          (core_p),
        .Q          (core_q)
    );

    always_comb begin
        out_d      = OUT_RST;
        out_d.y    = core_f;
        out_d.co_n = (mode_e'(M) == MODE_LOGIC) ? 1'b1 : ~core_cout;
        out_d.p    = core_p;
        out_d.q    = core_q;
        out_d.aeqb = (core_f == {W{1'b1}});
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q <= OUT_RST;
        end else begin
            out_q <= out_d;
        end
    end

    assign Y          = out_q.y;
    assign Co_inverse = out_q.co_n;
    assign P          = out_q.p;
    assign Q          = out_q.q;
    assign AequalsB   = out_q.aeqb;

`ifdef ALU_ZERO_FLAG_EN
    logic z_d;
    logic z_q;

    assign z_d = (core_f == {W{1'b0}});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            z_q <= Z_RST;
        end else begin
            z_q <= z_d;
        end
    end

    assign Z = z_q;
`endif

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - scoreboard bench for alu with directed hand-computed vectors
module tb_alu;

    typedef struct {
        logic [3:0] y;
        logic       co_n;
        logic       p;
        logic       q;
        logic       aeqb;
        logic       z;
        string      name;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] s;
    logic       M;
    logic       Ci_inverse;
    logic [3:0] Y;
    logic       Co_inverse;
    logic       P;
    logic       Q;
    logic       AequalsB;
`ifdef ALU_ZERO_FLAG_EN
    logic       Z;
`endif

    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    alu dut (
        .clk        (clk),
        .reset      (reset),
        .a          (a),
        .b          (b),
        .s          (s),
        .M          (M),
        .Ci_inverse (Ci_inverse),
        .Y          (Y),
        .Co_inverse (Co_inverse),
        .P          (P),
        .Q          (Q),
        .AequalsB   (AequalsB)
`ifdef ALU_ZERO_FLAG_EN
        ,
        .Z          (Z)
`endif
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input exp_t e);
        chk({e.name, ".Y"}, int'(Y), int'(e.y));
        chk({e.name, ".Co_inverse"}, int'(Co_inverse), int'(e.co_n));
        chk({e.name, ".P"}, int'(P), int'(e.p));
        chk({e.name, ".Q"}, int'(Q), int'(e.q));
        chk({e.name, ".AequalsB"}, int'(AequalsB), int'(e.aeqb));
`ifdef ALU_ZERO_FLAG_EN
        chk({e.name, ".Z"}, int'(Z), int'(e.z));
`endif
    endtask

    function automatic exp_t mk(input string name, input logic [3:0] y, input logic co_n,
                                input logic p, input logic q, input logic aeqb, input logic z);
        exp_t e;
        e.name = name; e.y = y; e.co_n = co_n; e.p = p; e.q = q; e.aeqb = aeqb; e.z = z;
        return e;
    endfunction

    task automatic issue(input logic [3:0] ia, input logic [3:0] ib, input logic [3:0] is,
                         input logic im, input logic ici, input exp_t e);
        @(negedge clk);
        a = ia; b = ib; s = is; M = im; Ci_inverse = ici;
        sb.push_back(e);
    endtask

    // Monitor: every edge that has a pending expectation must present it
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk_out(e);
            end
        end
    end

    exp_t rst_e;

    initial begin
        rst_e = mk("reset", 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        a = 4'h0; b = 4'h0; s = 4'h0; M = 1'b0; Ci_inverse = 1'b1;
        #1;
        chk_out(rst_e);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        issue(4'b0011, 4'b0100, 4'b1001, 1'b0, 1'b1, mk("add3p4",   4'b0111, 1, 1, 1, 0, 0));
        issue(4'b1001, 4'b1000, 4'b1001, 1'b0, 1'b1, mk("add9p8",   4'b0001, 0, 1, 0, 0, 0));
        issue(4'b0101, 4'b0011, 4'b0110, 1'b0, 1'b0, mk("sub5m3",   4'b0010, 0, 1, 0, 0, 0));
        issue(4'b0101, 4'b0101, 4'b0110, 1'b0, 1'b1, mk("sub5m5m1", 4'b1111, 1, 0, 1, 1, 0));
        issue(4'b1100, 4'b1010, 4'b0110, 1'b1, 1'b1, mk("xor",      4'b0110, 1, 1, 0, 0, 0));
        issue(4'b1100, 4'b1010, 4'b1011, 1'b1, 1'b0, mk("and",      4'b1000, 1, 0, 0, 0, 0));
        issue(4'b1100, 4'b1010, 4'b1110, 1'b1, 1'b1, mk("or",       4'b1110, 1, 1, 0, 0, 0));
        issue(4'b1100, 4'b1010, 4'b0000, 1'b1, 1'b1, mk("nota",     4'b0011, 1, 1, 1, 0, 0));
        issue(4'b0110, 4'b1001, 4'b0011, 1'b0, 1'b1, mk("ones",     4'b1111, 1, 0, 1, 1, 0));
        issue(4'b1011, 4'b0101, 4'b1100, 1'b0, 1'b1, mk("dbl",      4'b0110, 0, 1, 0, 0, 0));
        issue(4'b0000, 4'b0000, 4'b1001, 1'b0, 1'b1, mk("zero",     4'b0000, 1, 1, 1, 0, 1));
        issue(4'b0000, 4'b0000, 4'b0011, 1'b0, 1'b0, mk("wrap",     4'b0000, 0, 0, 1, 0, 1));

        // Inputs changing between edges must not reach the outputs
        @(posedge clk);
        #3;
        a = 4'b1111; b = 4'b1111; s = 4'b1001; M = 1'b0; Ci_inverse = 1'b0;
        #1;
        chk_out(mk("hold_between_edges", 4'b0000, 0, 0, 1, 0, 1));

        // Mid-cycle reset discards the pending result and holds reset values
        @(negedge clk);
        a = 4'b0011; b = 4'b0100; s = 4'b1001; M = 1'b0; Ci_inverse = 1'b1;
        @(posedge clk);
        #2;
        a = 4'b0101; b = 4'b0101; s = 4'b0110;
        #1;
        reset = 1'b1;
        #1;
        chk_out(mk("async_reset", 4'b0000, 1, 1, 1, 0, 0));
        @(posedge clk);
        #1;
        chk_out(mk("reset_hold", 4'b0000, 1, 1, 1, 0, 0));
        @(negedge clk);
        reset = 1'b0;
        sb.push_back(mk("first_after_reset", 4'b1111, 1, 0, 1, 1, 0));

        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
